piso_serializer: RTL
====================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a one-word holding buffer for back-to-back frames, an external bit-enable for rate pacing, selectable bit order and optional parity. It is the general successor to the fixed 7-bit start/done shifter. It sits between a word producer (ALU/register-file test path) and any bit-serial sink (serial link, LED/pin driver, checker).

## Interface
- `WIDTH`, 7, data bits per word (≥2)
- `MSB_FIRST`, 0, 0 = LSB transmitted first, 1 = MSB first
- `PARITY`, 0, 0 = none, 1 = even parity bit appended, 2 = odd parity bit appended
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_data`  in  WIDTH  parallel word
- `in_valid`  in  1  producer offers `in_data`
- `in_ready`  out  1  holding buffer empty; word accepted on edge where `in_valid && in_ready`
- `bit_en`  in  1  advance to next serial bit on this edge (tie 1 for one bit per cycle)
- `ser_out`  out  1  current serial bit
- `ser_valid`  out  1  `ser_out` carries a frame bit
- `ser_last`  out  1  current bit is the final bit of the frame
- `busy`  out  1  frame in progress or word held
- `done`  out  1  one-cycle pulse: a frame completed

## Operation
- FRAME_LEN = WIDTH + (PARITY != 0 ? 1 : 0). Bit counter width = clog2(FRAME_LEN).
- Holding buffer: `hold_data`, `hold_full`. On accept: `hold_data <= in_data`, `hold_full <= 1`. `in_ready = rst_n & ~hold_full` (combinational from register).
- Parity computed on the held word at load: even = XOR of data bits, odd = its inverse; always transmitted after all data bits regardless of `MSB_FIRST`.
- FSM states IDLE, SHIFT.
  - IDLE: if `hold_full`, load shift register (data in transmit order + parity), `cnt <= 0`, clear `hold_full`, go SHIFT. `bit_en` ignored.
  - SHIFT: on `bit_en`: if `cnt == FRAME_LEN-1`, frame ends, `done <= 1`; then if `hold_full` reload immediately and stay SHIFT (no gap), else go IDLE. Otherwise shift one position, `cnt <= cnt+1`. Without `bit_en` hold current bit.
- `ser_valid` = (state == SHIFT). `ser_out` = shift-register head when `ser_valid`, else 0. `ser_last` = `ser_valid && cnt == FRAME_LEN-1`.
- `busy` = (state == SHIFT) | `hold_full`.
- An accept cannot coincide with a drain of the buffer (in_ready is low while full); a new word is accepted from the cycle after the drain.

## Timing
- Reset (`rst_n` low at a posedge): state IDLE, `hold_full`=0, `cnt`=0, shift register 0; `ser_out`, `ser_valid`, `ser_last`, `busy`, `done` = 0; `in_ready` = 0 while `rst_n` low, 1 from first cycle after release.
- Reset mid-frame: frame aborted, held word discarded, no `done`.
- Latency: word accepted at edge N in IDLE → first bit on `ser_out` with `ser_valid`=1 after edge N+1.
- Each bit is presented from the edge it becomes current until the `bit_en` edge that consumes it (≥1 cycle).
- `done` high for exactly the cycle after the edge consuming the last bit; in back-to-back mode it coincides with the first bit of the next frame.
- With `bit_en`=1 continuously and words always pre-held: sustained throughput one frame per FRAME_LEN cycles, `ser_valid` continuous.

## Test plan
- WIDTH=7, LSB first, no parity, `bit_en`=1, send 7'h4D → `ser_out` 1,0,1,1,0,0,1 on 7 consecutive cycles starting one cycle after accept; `ser_last` on 7th; `done` pulse next cycle; `busy` falls with it.
- MSB_FIRST=1, send 7'h4D → 1,0,0,1,1,0,1.
- PARITY=1, send 7'h4D (four ones) → 8-bit frame, 8th bit 0; PARITY=2 → 8th bit 1; send 7'h01 with PARITY=1 → 8th bit 1.
- Back-to-back: 7'h7F then 7'h00 offered continuously → 14 contiguous `ser_valid` cycles (seven 1s, seven 0s), `in_ready` low from second accept until first frame's final bit consumed, `done` pulses twice 7 cycles apart.
- Pacing: `bit_en` high every 3rd cycle → each bit held exactly 3 cycles; `bit_en` pulses while IDLE produce no output change.
- Reset asserted after 3 bits of 7'h55 with a second word held → next cycle all outputs 0, no `done`; after release a new word 7'h0F serializes cleanly from bit 0 with no residue.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word intake into a one-word holding buffer,
// bit_en-paced serial output with selectable bit order and optional trailing parity bit.
module piso_serializer #(
    parameter int WIDTH     = 7,
    parameter int MSB_FIRST = 0,
    parameter int PARITY    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic             done
);
    localparam int FRAME_LEN = WIDTH + ((PARITY != 0) ? 1 : 0);
    localparam int CW        = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] sr_q, sr_d;
    logic [WIDTH-1:0]     hold_data_q, hold_data_d;
    logic                 hold_full_q, hold_full_d;
    logic                 done_q, done_d;
    logic                 load_frame;

    // Shift register holds the frame in transmit order; bit 0 is always the current bit.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] d);
        logic [FRAME_LEN-1:0] f;
        f = '0;
        for (int i = 0; i < WIDTH; i++) begin
            f[i] = (MSB_FIRST != 0) ? d[WIDTH-1-i] : d[i];
        end
        if (PARITY == 1) begin
            f[FRAME_LEN-1] = ^d;
        end else if (PARITY == 2) begin
            f[FRAME_LEN-1] = ~^d;
        end
        return f;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        load_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    if (cnt_q == LAST_CNT) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_frame) begin
            sr_d        = build_frame(hold_data_q);
            cnt_d       = '0;
            hold_full_d = 1'b0;
            state_d     = SHIFT;
        end

        // in_ready is low while full, so this never collides with the drain above.
        if (in_valid && in_ready) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = rst_n & ~hold_full_q;
    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = ser_valid & sr_q[0];
    assign ser_last  = ser_valid & (cnt_q == LAST_CNT);
    assign busy      = ser_valid | hold_full_q;
    assign done      = done_q;

endmodule
